// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type, default sizes and width helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    // Width of a requester index; never below one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the beat counter: enough to hold MAX_BURST itself
    function automatic int cnt_w(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin winner selection starting just after the last granted requester
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   last_grant,
    output logic            found,
    output logic [IW-1:0]   winner
);

    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     pos;

    assign doubled = {valid, valid};
    assign rot     = NREQ'(doubled >> (int'(last_grant) + 1));
    assign found   = |valid;
    assign winner  = IW'((int'(pos) + int'(last_grant) + 1) % NREQ);

    // Priority-encode the rotated vector: lowest set bit is nearest after last_grant
    always_comb begin
        pos = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) pos = IW'(i);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync_fifo write port among NREQ producers
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr,
    output logic [WIDTH-1:0]        fifo_data,
    output logic [idx_w(NREQ)-1:0]  grant_id,
    output logic                    busy
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(MAX_BURST);

    state_t           state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    winner;
    logic [CW-1:0]    beat_cnt;
    logic             found;
    logic             open;
    logic             done;
    logic [WIDTH-1:0] slice [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .valid      (req_valid),
        .last_grant (last_grant),
        .found      (found),
        .winner     (winner)
    );

    // Ready depends only on state, owner and full, never on req_valid
    assign open      = (state == GRANT) & ~fifo_full;
    assign req_ready = open ? (NREQ'(1) << owner) : '0;
    assign fifo_wr   = open & req_valid[owner];
    assign fifo_data = slice[owner];
    assign done      = fifo_wr & (req_last[owner] | (beat_cnt == CW'(MAX_BURST - 1)));
    assign grant_id  = owner;
    assign busy      = (state == GRANT);

    // Arbitrate in IDLE, hold the grant through a burst, release on last or burst limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= IW'(NREQ - 1);
            beat_cnt   <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                owner    <= winner;
                beat_cnt <= '0;
                state    <= GRANT;
            end
        end else if (fifo_wr) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (done) begin
                state      <= IDLE;
                last_grant <= owner;
            end
        end
    end

endmodule
